// File: rtl/agc_controller.sv
// ============================================================================
// agc_controller : windowed-peak AGC stepping a 3-bit IF gain; manual bypass.
// Optional: `define AGC_FAST_ATTACK_EN for early window exit on clipping.
// Rev 1.0
// ============================================================================
`default_nettype none

module agc_controller #(
   parameter int WIN_LOG2       = 8,
   parameter int HI_THRESH      = 200,
   parameter int LO_THRESH      = 64,
   parameter int SETTLE_WINDOWS = 2,
   parameter int CLIP_LEVEL     = 250
) (
   input  logic       clk,
   input  logic       RSTb,
   input  logic       agc_en,
   input  logic [2:0] gain_manual,
   input  logic [7:0] env_in,
   input  logic       env_valid,
   output logic [2:0] gain_out,
   output logic       gain_step,
   output logic [7:0] peak_out,
   output logic       in_range
);

   localparam int SET_TOTAL = SETTLE_WINDOWS * (2 ** WIN_LOG2);
   localparam int SET_W     = (SET_TOTAL > 1) ? $clog2(SET_TOTAL) : 1;

   localparam logic [7:0]       C_HI       = HI_THRESH[7:0];
   localparam logic [7:0]       C_LO       = LO_THRESH[7:0];
   localparam logic [7:0]       C_CLIP     = CLIP_LEVEL[7:0];
   localparam logic [SET_W-1:0] C_SET_LAST = SET_W'((SET_TOTAL > 0) ? SET_TOTAL - 1 : 0);
`ifdef AGC_FAST_ATTACK_EN
   localparam bit C_FAST = 1'b1;
`else
   localparam bit C_FAST = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MEASURE = 2'd1,
      S_DECIDE  = 2'd2,
      S_SETTLE  = 2'd3
   } state_t;

   state_t              r_state;
   logic [2:0]          r_gain;
   logic                r_step;
   logic [7:0]          r_peak;
   logic                r_in_range;
   logic [7:0]          r_acc;
   logic [WIN_LOG2-1:0] r_win_cnt;
   logic [SET_W-1:0]    r_set_cnt;

   logic [7:0] w_acc_next;
   logic       w_win_last;
   logic       w_early;
   logic       w_hi;
   logic       w_lo;

   assign w_acc_next = (env_in > r_acc) ? env_in : r_acc;
   assign w_win_last = (r_win_cnt == {WIN_LOG2{1'b1}});
   // A clipping sample can only shorten the window when there is gain left to drop.
   assign w_early    = C_FAST && (env_in >= C_CLIP) && (r_gain != 3'd0);
   assign w_hi       = (r_acc >= C_HI);
   assign w_lo       = (r_acc < C_LO);

   always_ff @(posedge clk or negedge RSTb) begin
      if (!RSTb) begin
         r_state    <= S_IDLE;
         r_gain     <= 3'd4;
         r_step     <= 1'b0;
         r_peak     <= 8'd0;
         r_in_range <= 1'b0;
         r_acc      <= 8'd0;
         r_win_cnt  <= '0;
         r_set_cnt  <= '0;
      end else begin
         r_step <= 1'b0;
         if (r_state != S_IDLE && !agc_en) begin
            r_state   <= S_IDLE;
            r_gain    <= gain_manual;
            r_acc     <= 8'd0;
            r_win_cnt <= '0;
            r_set_cnt <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (agc_en) begin
                     r_state   <= S_MEASURE;
                     r_acc     <= 8'd0;
                     r_win_cnt <= '0;
                     r_set_cnt <= '0;
                  end else begin
                     r_gain <= gain_manual;
                  end
               end
               S_MEASURE: begin
                  if (env_valid) begin
                     r_acc     <= w_acc_next;
                     r_win_cnt <= r_win_cnt + 1'b1;
                     if (w_win_last || w_early) begin
                        r_state <= S_DECIDE;
                     end
                  end
               end
               S_DECIDE: begin
                  r_peak    <= r_acc;
                  r_acc     <= 8'd0;
                  r_win_cnt <= '0;
                  r_set_cnt <= '0;
                  if (w_hi && r_gain != 3'd0) begin
                     r_gain     <= r_gain - 3'd1;
                     r_step     <= 1'b1;
                     r_in_range <= 1'b0;
                     r_state    <= (SET_TOTAL > 0) ? S_SETTLE : S_MEASURE;
                  end else if (w_lo && r_gain != 3'd7) begin
                     r_gain     <= r_gain + 3'd1;
                     r_step     <= 1'b1;
                     r_in_range <= 1'b0;
                     r_state    <= (SET_TOTAL > 0) ? S_SETTLE : S_MEASURE;
                  end else begin
                     r_in_range <= !w_hi && !w_lo;
                     r_state    <= S_MEASURE;
                  end
               end
               S_SETTLE: begin
                  if (env_valid) begin
                     if (r_set_cnt == C_SET_LAST) begin
                        r_set_cnt <= '0;
                        r_state   <= S_MEASURE;
                     end else begin
                        r_set_cnt <= r_set_cnt + 1'b1;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign gain_out  = r_gain;
   assign gain_step = r_step;
   assign peak_out  = r_peak;
   assign in_range  = r_in_range;

endmodule

`default_nettype wire

// File: tb/tb_agc_controller.sv
// ============================================================================
// tb_agc_controller : scoreboard bench for agc_controller (WIN_LOG2=4, 1 settle window).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_agc_controller;

   logic       clk = 1'b0;
   logic       RSTb = 1'b0;
   logic       agc_en = 1'b0;
   logic [2:0] gain_manual = 3'd0;
   logic [7:0] env_in = 8'd0;
   logic       env_valid = 1'b0;
   logic [2:0] gain_out;
   logic       gain_step;
   logic [7:0] peak_out;
   logic       in_range;

   always #5 clk = ~clk;

   agc_controller #(
      .WIN_LOG2(4), .HI_THRESH(200), .LO_THRESH(64),
      .SETTLE_WINDOWS(1), .CLIP_LEVEL(250)
   ) u_dut (
      .clk(clk), .RSTb(RSTb), .agc_en(agc_en), .gain_manual(gain_manual),
      .env_in(env_in), .env_valid(env_valid), .gain_out(gain_out),
      .gain_step(gain_step), .peak_out(peak_out), .in_range(in_range)
   );

   typedef struct packed {
      logic [2:0] gain;
      logic [7:0] peak;
      logic       inr;
      logic       step;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   pulses = 0;
   int   exp_pulses = 0;
   int   tb_gain = 4;
   int   tb_peak = 0;
   int   tb_inr = 0;
   logic [7:0] win[16];
   int   nsamp = 16;
   int   gap = 0;
   logic [7:0] settle_val = 8'd0;

   always @(negedge clk) if (RSTb && gain_step === 1'b1) pulses++;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      @(negedge clk);
      env_valid = v;
      env_in    = d;
   endtask

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 16; i++) win[i] = v;
   endtask

   // Leave AGC, load a manual gain, then re-enable with a fresh window.
   task automatic set_mode(input int g);
      @(negedge clk);
      agc_en = 1'b0; env_valid = 1'b0; gain_manual = 3'(g);
      @(posedge clk); #1;
      check("manual_gain", gain_out, g);
      check("manual_no_step", gain_step, 0);
      check("peak_hold", peak_out, tb_peak);
      check("inr_hold", in_range, tb_inr);
      @(negedge clk);
      agc_en = 1'b1;
      @(posedge clk); #1;
      check("enable_gain_hold", gain_out, g);
      tb_gain = g;
   endtask

   task automatic run_window(input string tag);
      exp_t e;
      int   pk;
      pk = 0;
      for (int i = 0; i < nsamp; i++) if (int'(win[i]) > pk) pk = int'(win[i]);
      e.gain = 3'(tb_gain); e.peak = 8'(pk); e.inr = 1'b0; e.step = 1'b0;
      if (pk >= 200 && tb_gain > 0) begin
         e.gain = 3'(tb_gain - 1); e.step = 1'b1;
      end else if (pk < 64 && tb_gain < 7) begin
         e.gain = 3'(tb_gain + 1); e.step = 1'b1;
      end else begin
         e.inr = (pk >= 64 && pk < 200);
      end
      sb.push_back(e);
      for (int i = 0; i < nsamp; i++) begin
         for (int k = 0; k < gap; k++) step(1'b0, 8'd0);
         @(negedge clk);
         if (i == nsamp - 1) begin
            check({tag, "_no_early_gain"}, gain_out, tb_gain);
            check({tag, "_no_early_pulse"}, pulses, exp_pulses);
         end
         env_valid = 1'b1;
         env_in    = win[i];
      end
      @(negedge clk);
      env_valid = 1'b0;
      @(posedge clk); #1;
      e = sb.pop_front();
      check({tag, "_gain"}, gain_out, e.gain);
      check({tag, "_peak"}, peak_out, e.peak);
      check({tag, "_in_range"}, in_range, e.inr);
      check({tag, "_step"}, gain_step, e.step);
      tb_gain = e.gain;
      tb_peak = pk;
      tb_inr  = e.inr;
      if (e.step) begin
         exp_pulses++;
         @(posedge clk); #1;
         check({tag, "_step_width"}, gain_step, 0);
         for (int i = 0; i < 16; i++) step(1'b1, settle_val);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_gain", gain_out, 4);
      check("rst_step", gain_step, 0);
      check("rst_peak", peak_out, 0);
      check("rst_inr", in_range, 0);
      @(negedge clk);
      RSTb = 1'b1;

      // manual pass-through then attack
      set_mode(6);
      fill(8'd220);  run_window("attack");
      fill(8'd100);  run_window("after_settle");

      // decay to the upper limit
      set_mode(4);
      settle_val = 8'd10;
      fill(8'd10);
      for (int n = 0; n < 5; n++) run_window("decay");
      settle_val = 8'd0;

      // threshold boundaries
      set_mode(3); fill(8'd200); run_window("hi_200");
      set_mode(3); fill(8'd64);  run_window("lo_64");
      set_mode(3); fill(8'd63);  run_window("lo_63");
      set_mode(3); fill(8'd100); win[15] = 8'd200; run_window("last_200");

      // sparse strobes
      set_mode(3); fill(8'd30); gap = 2; run_window("gap3"); gap = 0;

      // abort mid-window then fresh window
      set_mode(3);
      for (int i = 0; i < 7; i++) step(1'b1, 8'd220);
      @(negedge clk);
      agc_en = 1'b0; env_valid = 1'b0; gain_manual = 3'd5;
      @(posedge clk); #1;
      check("abort_gain", gain_out, 5);
      check("abort_step", gain_step, 0);
      check("abort_peak_hold", peak_out, tb_peak);
      check("abort_inr_hold", in_range, tb_inr);
      @(negedge clk);
      agc_en = 1'b1;
      @(posedge clk); #1;
      tb_gain = 5;
      fill(8'd30); run_window("reenable");

      // clipping sample as the 3rd sample
      set_mode(4);
      fill(8'd100); win[2] = 8'd252;
`ifdef AGC_FAST_ATTACK_EN
      nsamp = 3;
`else
      nsamp = 16;
`endif
      run_window("clip");
      nsamp = 16;

      check("pulse_total", pulses, exp_pulses);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
